// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter and its wb_ram slave:
// FSM state encoding and default bus widths.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam int unsigned WB_NUM_M       = 2;
  localparam int unsigned WB_D_WIDTH     = 32;
  localparam int unsigned WB_A_WIDTH     = 8;
  localparam int unsigned WB_GRANULARITY = 8;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// "master" is the arbiter's view (it masters the RAM); "slave" is the environment's view.
interface wb_rr_arbiter_if
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M       = WB_NUM_M,
  parameter int unsigned D_WIDTH     = WB_D_WIDTH,
  parameter int unsigned A_WIDTH     = WB_A_WIDTH,
  parameter int unsigned GRANULARITY = WB_GRANULARITY
);
  localparam int unsigned G_WIDTH = D_WIDTH / GRANULARITY;

  logic [NUM_M-1:0]         m_cyc_i;
  logic [NUM_M-1:0]         m_stb_i;
  logic [NUM_M-1:0]         m_we_i;
  logic [NUM_M*A_WIDTH-1:0] m_adr_i;
  logic [NUM_M*D_WIDTH-1:0] m_dat_i;
  logic [NUM_M*G_WIDTH-1:0] m_sel_i;
  logic [D_WIDTH-1:0]       m_dat_o;
  logic [NUM_M-1:0]         m_ack_o;
  logic [NUM_M-1:0]         gnt_o;
  logic                     s_stb_o;
  logic                     s_we_o;
  logic [A_WIDTH-1:0]       s_adr_o;
  logic [D_WIDTH-1:0]       s_dat_o;
  logic [G_WIDTH-1:0]       s_sel_o;
  logic [D_WIDTH-1:0]       s_dat_i;
  logic                     s_ack_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, gnt_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, gnt_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i,
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned k;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    // offset NUM_M revisits last_i itself, so a lone repeat requester still wins
    for (int unsigned off = 1; off <= NUM_M; off++) begin
      k = (32'(last_i) + off) % NUM_M;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one single-port RAM,
// grant held per cyc tenure, at most one outstanding strobe.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M       = WB_NUM_M,
  parameter int unsigned D_WIDTH     = WB_D_WIDTH,
  parameter int unsigned A_WIDTH     = WB_A_WIDTH,
  parameter int unsigned GRANULARITY = WB_GRANULARITY
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_rr_arbiter_if.master bus
);

  localparam int unsigned G_WIDTH = D_WIDTH / GRANULARITY;
  localparam int unsigned IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  arb_state_e         state, state_n;
  logic [NUM_M-1:0]   gnt, gnt_n, pick_gnt;
  logic [IDX_W-1:0]   last, last_n, pick_idx;
  logic               g_cyc, g_stb, stb, ack_en;
  logic               we_mux;
  logic [A_WIDTH-1:0] adr_mux;
  logic [D_WIDTH-1:0] dat_mux;
  logic [G_WIDTH-1:0] sel_mux;

  rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
    .req_i  (bus.m_cyc_i),
    .last_i (last),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign g_cyc = |(bus.m_cyc_i & gnt);
  assign g_stb = |(bus.m_stb_i & gnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      last  <= IDX_W'(NUM_M - 1);
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    stb     = 1'b0;
    ack_en  = 1'b0;
    case (state)
      ARB_IDLE: begin
        // s_ack_i deliberately ignored here: drops a stale ack after reset
        if (|bus.m_cyc_i) begin
          gnt_n   = pick_gnt;
          last_n  = pick_idx;
          state_n = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!g_cyc) begin
          gnt_n   = '0;
          state_n = ARB_IDLE;
        end else if (g_stb) begin
          stb     = 1'b1;
          state_n = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.s_ack_i) begin
          ack_en = 1'b1;
          if (!g_cyc) begin
            gnt_n   = '0;
            state_n = ARB_IDLE;
          end else begin
            state_n = ARB_BUSY;
          end
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = ARB_IDLE;
      end
    endcase
  end

  // AND-OR mux keyed by the one-hot grant; all zero when nothing is granted
  always_comb begin
    we_mux  = 1'b0;
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (gnt[k]) begin
        we_mux  = we_mux  | bus.m_we_i[k];
        adr_mux = adr_mux | bus.m_adr_i[k*A_WIDTH +: A_WIDTH];
        dat_mux = dat_mux | bus.m_dat_i[k*D_WIDTH +: D_WIDTH];
        sel_mux = sel_mux | bus.m_sel_i[k*G_WIDTH +: G_WIDTH];
      end
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.m_ack_o = ack_en ? gnt : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.s_stb_o = stb;
  assign bus.s_we_o  = we_mux;
  assign bus.s_adr_o = adr_mux;
  assign bus.s_dat_o = dat_mux;
  assign bus.s_sel_o = sel_mux;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter with a behavioural one-cycle-ack RAM.
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned GR = 8;
  localparam int unsigned GW = DW / GR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_M(NM), .D_WIDTH(DW), .A_WIDTH(AW), .GRANULARITY(GR)) bus ();

  wb_rr_arbiter #(.NUM_M(NM), .D_WIDTH(DW), .A_WIDTH(AW), .GRANULARITY(GR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // RAM model: registered ack (optionally 3 cycles late), not cleared by rst
  logic [DW-1:0] mem [0:255];
  logic [2:0]    ack_sr = '0;
  logic [DW-1:0] ram_q  = '0;
  bit            slow_ack = 1'b0;

  always @(posedge clk) begin
    ack_sr <= {ack_sr[1:0], bus.s_stb_o};
    if (bus.s_stb_o) begin
      if (bus.s_we_o)
        for (int i = 0; i < GW; i++)
          if (bus.s_sel_o[i]) mem[bus.s_adr_o][i*GR +: GR] <= bus.s_dat_o[i*GR +: GR];
      ram_q <= mem[bus.s_adr_o];
    end
    if (rst) begin
      mem[5]  <= 32'hDEADBEEF;
      mem[6]  <= 32'hCAFEF00D;
      mem[16] <= 32'h0;
    end
  end

  assign bus.s_dat_i = ram_q;
  assign bus.s_ack_i = slow_ack ? ack_sr[2] : ack_sr[0];

  typedef struct {
    logic [NM-1:0] ack;
    logic [DW-1:0] dat;
    bit            chk_dat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.m_ack_o != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_ack: got %b expected none", bus.m_ack_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", 32'(bus.m_ack_o), 32'(e.ack));
        if (e.chk_dat) chk("sb_dat", bus.m_dat_o, e.dat);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = {8'h06, 8'h05};
    bus.m_dat_i = '0;
    bus.m_sel_i = '1;
  endtask

  // One read tenure: request, grant+stb, ack, drop cyc, back to idle
  task automatic xfer(input string tag, input logic [NM-1:0] req, input int unsigned win,
                      input logic [AW-1:0] exp_adr, input logic [DW-1:0] exp_dat);
    logic [NM-1:0] w;
    w = NM'(1) << win;
    bus.m_cyc_i = req;
    bus.m_stb_i = req;
    samp(); chk({tag, "_gnt_c0"}, 32'(bus.gnt_o), 32'h0);
    nxt();  samp();
    chk({tag, "_gnt_c1"}, 32'(bus.gnt_o), 32'(w));
    chk({tag, "_stb_c1"}, 32'(bus.s_stb_o), 32'h1);
    chk({tag, "_adr_c1"}, 32'(bus.s_adr_o), 32'(exp_adr));
    sb.push_back('{ack: w, dat: exp_dat, chk_dat: 1'b1});
    nxt();  samp();
    chk({tag, "_ack_c2"}, 32'(bus.m_ack_o), 32'(w));
    nxt();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    samp();
    chk({tag, "_gnt_c3"}, 32'(bus.gnt_o), 32'(w));
    chk({tag, "_ack_c3"}, 32'(bus.m_ack_o), 32'h0);
    nxt();  samp(); chk({tag, "_gnt_c4"}, 32'(bus.gnt_o), 32'h0);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    nxt(); nxt(); samp();
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_stb", 32'(bus.s_stb_o), 32'h0);
    chk("rst_ack", 32'(bus.m_ack_o), 32'h0);
    chk("rst_adr", 32'(bus.s_adr_o), 32'h0);
    nxt();
    rst = 1'b0;

    // Single read by master 0
    xfer("single", 2'b01, 0, 8'h05, 32'hDEADBEEF);

    // Held strobe: master 1 writes lower half of word 0x10
    bus.m_we_i  = 2'b10;
    bus.m_adr_i = {8'h10, 8'h05};
    bus.m_dat_i = {32'h12345678, 32'h0};
    bus.m_sel_i = {4'b0011, 4'b1111};
    bus.m_cyc_i = 2'b10;
    bus.m_stb_i = 2'b10;
    samp(); chk("held_gnt_c0", 32'(bus.gnt_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      nxt(); samp();
      chk("held_gnt", 32'(bus.gnt_o), 32'h2);
      chk("held_stb", 32'(bus.s_stb_o), (i % 2 == 0) ? 32'h1 : 32'h0);
      if (i == 0) begin
        chk("held_we",  32'(bus.s_we_o), 32'h1);
        chk("held_sel", 32'(bus.s_sel_o), 32'h3);
        chk("held_dat", bus.s_dat_o, 32'h12345678);
        chk("held_adr", 32'(bus.s_adr_o), 32'h10);
      end
      if (i % 2 == 0) sb.push_back('{ack: 2'b10, dat: '0, chk_dat: 1'b0});
    end
    nxt();
    idle_inputs();
    samp(); chk("held_gnt_rel", 32'(bus.gnt_o), 32'h2);
    nxt(); samp();
    chk("held_gnt_idle", 32'(bus.gnt_o), 32'h0);
    chk("held_mem", mem[16], 32'h00005678);
    nxt();

    // Contention: round-robin 0, 1, 0
    xfer("cont0", 2'b11, 0, 8'h05, 32'hDEADBEEF);
    xfer("cont1", 2'b11, 1, 8'h06, 32'hCAFEF00D);
    xfer("cont2", 2'b11, 0, 8'h05, 32'hDEADBEEF);

    // Lock: master 0 keeps cyc for 3 transfers while master 1 waits
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    samp(); chk("lock_gnt_c0", 32'(bus.gnt_o), 32'h0);
    nxt();
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    samp();
    chk("lock_gnt_c1", 32'(bus.gnt_o), 32'h1);
    chk("lock_stb_c1", 32'(bus.s_stb_o), 32'h1);
    sb.push_back('{ack: 2'b01, dat: 32'hDEADBEEF, chk_dat: 1'b1});
    for (int j = 2; j <= 6; j++) begin
      nxt(); samp();
      chk("lock_gnt", 32'(bus.gnt_o), 32'h1);
      chk("lock_stb", 32'(bus.s_stb_o), (j % 2 == 1) ? 32'h1 : 32'h0);
      if (j % 2 == 1) sb.push_back('{ack: 2'b01, dat: 32'hDEADBEEF, chk_dat: 1'b1});
    end
    nxt();
    bus.m_cyc_i = 2'b10;
    bus.m_stb_i = 2'b10;
    samp(); chk("lock_gnt_drop", 32'(bus.gnt_o), 32'h1);
    nxt(); samp(); chk("lock_gnt_bubble", 32'(bus.gnt_o), 32'h0);
    nxt(); samp();
    chk("lock_gnt_m1", 32'(bus.gnt_o), 32'h2);
    chk("lock_adr_m1", 32'(bus.s_adr_o), 32'h06);
    sb.push_back('{ack: 2'b10, dat: 32'hCAFEF00D, chk_dat: 1'b1});
    nxt(); samp(); chk("lock_ack_m1", 32'(bus.m_ack_o), 32'h2);
    nxt();
    idle_inputs();
    nxt(); samp(); chk("lock_gnt_end", 32'(bus.gnt_o), 32'h0);
    nxt();

    // Reset while waiting for the RAM ack
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    nxt(); samp();
    chk("rstw_stb", 32'(bus.s_stb_o), 32'h1);
    nxt();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rstw_gnt_now", 32'(bus.gnt_o), 32'h0);
    samp(); chk("rstw_ack", 32'(bus.m_ack_o), 32'h0);
    nxt();
    rst = 1'b0;
    samp(); chk("rstw_gnt_after", 32'(bus.gnt_o), 32'h0);
    nxt();

    // Early cyc drop in WAIT with a slow ack; stb left high to probe WAIT masking
    slow_ack = 1'b1;
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    nxt(); samp();
    chk("early_gnt_c1", 32'(bus.gnt_o), 32'h1);
    sb.push_back('{ack: 2'b01, dat: 32'hDEADBEEF, chk_dat: 1'b1});
    nxt();
    bus.m_cyc_i = 2'b00;
    samp();
    chk("early_stb_wait", 32'(bus.s_stb_o), 32'h0);
    chk("early_gnt_c2", 32'(bus.gnt_o), 32'h1);
    nxt(); samp(); chk("early_gnt_c3", 32'(bus.gnt_o), 32'h1);
    nxt(); samp();
    chk("early_ack_c4", 32'(bus.m_ack_o), 32'h1);
    chk("early_gnt_c4", 32'(bus.gnt_o), 32'h1);
    nxt();
    idle_inputs();
    samp(); chk("early_gnt_c5", 32'(bus.gnt_o), 32'h0);
    slow_ack = 1'b0;

    nxt(); nxt(); nxt();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
